uart_rx_buffered: RTL and testbench

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_buffered_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_buffered.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// rtl/uart_rx_buffered_pkg.sv - shared types and tick-divider math for the buffered UART receiver
package uart_rx_buffered_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
        int d;
        d = clock_rate / (baud_rate * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO; a write while full succeeds only alongside a pop
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             push;
    logic             pop;

    assign rd_valid = (count_r != '0);
    assign full     = (count_r == CW'(DEPTH));
    assign pop      = rd_ready && rd_valid;
    assign push     = wr_en && (!full || pop);
    assign rd_data  = mem[rd_ptr];
    assign count    = count_r;

    // Storage carries no reset; the top gates the head with rd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_r <= count_r + CW'(1);
            end else if (pop && !push) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - oversampling UART receiver with majority voting and a buffered output
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLOCK_RATE    = 1_600_000,
    parameter int BAUD_RATE     = 100_000,
    parameter int RX_OVERSAMPLE = 16,
    parameter int PARITY_EN     = 0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_Rx_Data,
    input  logic                          i_Rd_Ready,
    input  logic                          i_Clear_Err,
    output logic                          o_Rx_Valid,
    output logic [7:0]                    o_Rx_Byte,
    output logic                          o_Frame_Err,
    output logic                          o_Parity_Err,
    output logic                          o_Overrun,
    output logic                          o_Rx_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(RX_OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] CNT_LO   = SW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] CNT_MID  = SW'(RX_OVERSAMPLE / 2);
    localparam logic [SW-1:0] CNT_HI   = SW'(RX_OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(RX_OVERSAMPLE - 1);

    logic            sync_meta;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    rx_state_t       state;
    rx_state_t       state_next;
    logic [SW-1:0]   samp_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            samp_lo;
    logic            samp_mid;
    logic            par_bit;
    logic            maj;
    logic            maj_tick;
    logic            end_tick;
    logic            busy;
    logic            fifo_wr;
    rx_entry_t       wr_entry;
    rx_entry_t       head;
    logic [ENTRY_W-1:0] wr_bits;
    logic [ENTRY_W-1:0] head_bits;
    logic            fifo_valid;
    logic            fifo_full;
    logic            overrun;
    logic            drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= i_Rx_Data;
            rx_s      <= sync_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // The two earlier samples are held so the vote completes on the third.
    assign maj      = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
    assign maj_tick = tick && (samp_cnt == CNT_HI);
    assign end_tick = tick && (samp_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (tick && !rx_s) state_next = ST_START;
            ST_START: begin
                if (maj_tick && maj) begin
                    state_next = ST_IDLE;
                end else if (end_tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_tick && bit_cnt == 3'd7) begin
                    state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY:    if (end_tick) state_next = ST_STOP;
            ST_STOP:      if (maj_tick) state_next = maj ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (tick && rx_s) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        fifo_wr  = 1'b0;
        wr_entry = '0;
        if (state == ST_STOP && maj_tick) begin
            fifo_wr             = 1'b1;
            wr_entry.data       = shreg;
            wr_entry.frame_err  = ~maj;
            wr_entry.parity_err = (PARITY_EN != 0) && ((^shreg) ^ par_bit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            samp_lo  <= 1'b1;
            samp_mid <= 1'b1;
            par_bit  <= 1'b0;
        end else if (tick) begin
            if (state == ST_IDLE || samp_cnt == CNT_LAST) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + SW'(1);
            end
            if (samp_cnt == CNT_LO) samp_lo <= rx_s;
            if (samp_cnt == CNT_MID) samp_mid <= rx_s;
            if (state == ST_START) bit_cnt <= '0;
            if (state == ST_DATA && samp_cnt == CNT_HI) shreg <= {maj, shreg[7:1]};
            if (state == ST_DATA && samp_cnt == CNT_LAST) bit_cnt <= bit_cnt + 3'd1;
            if (state == ST_PARITY && samp_cnt == CNT_HI) par_bit <= maj;
        end
    end

    assign wr_bits = wr_entry;
    assign head    = head_bits;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_wr),
        .wr_data  (wr_bits),
        .rd_ready (i_Rd_Ready),
        .rd_valid (fifo_valid),
        .rd_data  (head_bits),
        .full     (fifo_full),
        .count    (o_Fifo_Count)
    );

    // A full FIFO is never empty, so i_Rd_Ready alone tells whether a slot frees up.
    assign drop = fifo_wr && fifo_full && !i_Rd_Ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (i_Clear_Err) begin
            overrun <= 1'b0;
        end
    end

    assign o_Rx_Valid   = fifo_valid;
    assign o_Rx_Byte    = fifo_valid ? head.data : 8'h00;
    assign o_Frame_Err  = fifo_valid && head.frame_err;
    assign o_Parity_Err = fifo_valid && head.parity_err && (PARITY_EN != 0);
    assign o_Overrun    = overrun;
    assign o_Rx_Busy    = busy;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - self-checking bench for uart_rx_buffered (16 clk per bit)
module tb_uart_rx_buffered;
    localparam int BIT_CLK = 16;

    logic clk = 1'b0;
    logic reset;
    logic rx0, rd0, clr0, rx1, rd1, clr1;
    logic v0, fe0, pe0, ov0, bz0;
    logic v1, fe1, pe1, ov1, bz1;
    logic [7:0] b0, b1;
    logic [2:0] c0, c1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;
    vec_t tbl [6];

    logic [8:0] model_q [$];
    logic [8:0] ent;
    logic       exp_ovr;
    logic [7:0] rnd_data;
    logic       rnd_stop;
    int         nfr;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .RX_OVERSAMPLE(16),
        .PARITY_EN(0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .i_Rx_Data(rx0), .i_Rd_Ready(rd0), .i_Clear_Err(clr0),
        .o_Rx_Valid(v0), .o_Rx_Byte(b0), .o_Frame_Err(fe0), .o_Parity_Err(pe0),
        .o_Overrun(ov0), .o_Rx_Busy(bz0), .o_Fifo_Count(c0)
    );

    uart_rx_buffered #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .RX_OVERSAMPLE(16),
        .PARITY_EN(1), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .reset(reset), .i_Rx_Data(rx1), .i_Rd_Ready(rd1), .i_Clear_Err(clr1),
        .o_Rx_Valid(v1), .o_Rx_Byte(b1), .o_Frame_Err(fe1), .o_Parity_Err(pe1),
        .o_Overrun(ov1), .o_Rx_Busy(bz1), .o_Fifo_Count(c1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic send_body(input int which, input logic [7:0] data, input logic use_par,
                             input logic par, input logic stop);
        set_line(which, 1'b0);
        cyc(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            set_line(which, data[i]);
            cyc(BIT_CLK);
        end
        if (use_par) begin
            set_line(which, par);
            cyc(BIT_CLK);
        end
        set_line(which, stop);
        cyc(BIT_CLK);
    endtask

    task automatic send(input int which, input logic [7:0] data, input logic use_par,
                        input logic par, input logic stop, input int low_hold);
        send_body(which, data, use_par, par, stop);
        if (!stop) cyc(low_hold);
        set_line(which, 1'b1);
        cyc(6);
    endtask

    // The stop-bit vote lands on the 157th clk after the start edge is driven.
    task automatic send_pulse(input logic [7:0] data, input logic pulse_rd, input logic pulse_clr);
        fork
            send(0, data, 1'b0, 1'b0, 1'b1, 0);
            begin
                cyc(156);
                rd0 = pulse_rd;
                clr0 = pulse_clr;
                cyc(1);
                rd0 = 1'b0;
                clr0 = 1'b0;
            end
        join
    endtask

    task automatic check_pop(input int which, input string name, input logic [7:0] eb,
                             input logic efe, input logic epe);
        if (which == 0) begin
            chk({name, "_valid"}, 32'(v0), 32'd1);
            chk({name, "_byte"}, 32'(b0), 32'(eb));
            chk({name, "_ferr"}, 32'(fe0), 32'(efe));
            chk({name, "_perr"}, 32'(pe0), 32'(epe));
            rd0 = 1'b1;
            cyc(1);
            rd0 = 1'b0;
        end else begin
            chk({name, "_valid"}, 32'(v1), 32'd1);
            chk({name, "_byte"}, 32'(b1), 32'(eb));
            chk({name, "_ferr"}, 32'(fe1), 32'(efe));
            chk({name, "_perr"}, 32'(pe1), 32'(epe));
            rd1 = 1'b1;
            cyc(1);
            rd1 = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, 32'(v0), 32'd0);
        chk({name, "_byte"}, 32'(b0), 32'd0);
        chk({name, "_ferr"}, 32'(fe0), 32'd0);
        chk({name, "_perr"}, 32'(pe0), 32'd0);
        chk({name, "_ovr"}, 32'(ov0), 32'd0);
        chk({name, "_busy"}, 32'(bz0), 32'd0);
        chk({name, "_count"}, 32'(c0), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rx0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0;
        rx1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0;
        tbl[0] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        cyc(3);
        check_reset_outputs("rst");
        chk("rst_p_perr", 32'(pe1), 32'd0);
        chk("rst_p_count", 32'(c1), 32'd0);
        reset = 1'b0;
        cyc(4);

        // Single good frame held until read
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
        chk("a5_count", 32'(c0), 32'd1);
        check_pop(0, "a5", 8'hA5, 1'b0, 1'b0);
        chk("a5_count_pop", 32'(c0), 32'd0);

        // Short low glitch is a false start
        rx0 = 1'b0;
        cyc(4);
        chk("glitch_busy_rise", 32'(bz0), 32'd1);
        rx0 = 1'b1;
        for (int k = 0; k < 16 && bz0; k++) cyc(1);
        chk("glitch_busy_fall", 32'(bz0), 32'd0);
        cyc(4);
        chk("glitch_count", 32'(c0), 32'd0);

        // Low stop bit followed by a break
        send_body(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        cyc(40);
        chk("brk_busy", 32'(bz0), 32'd1);
        chk("brk_count", 32'(c0), 32'd1);
        rx0 = 1'b1;
        for (int k = 0; k < 8 && bz0; k++) cyc(1);
        chk("brk_busy_release", 32'(bz0), 32'd0);
        check_pop(0, "brk", 8'h3C, 1'b1, 1'b0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
        check_pop(0, "after_brk", 8'h55, 1'b0, 1'b0);

        // Overrun; a clear coinciding with a fresh drop leaves the flag set
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0, 1'b1, 0);
        chk("ovr_count", 32'(c0), 32'd4);
        chk("ovr_flag", 32'(ov0), 32'd1);
        send_pulse(8'h06, 1'b0, 1'b1);
        chk("ovr_clear_race", 32'(ov0), 32'd1);
        for (int i = 1; i <= 4; i++) check_pop(0, $sformatf("ovr_rd%0d", i), 8'(i), 1'b0, 1'b0);
        chk("ovr_drained", 32'(c0), 32'd0);
        clr0 = 1'b1;
        cyc(1);
        clr0 = 1'b0;
        chk("ovr_cleared", 32'(ov0), 32'd0);

        // Write into a full FIFO alongside a pop
        for (int i = 1; i <= 4; i++) send(0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 0);
        send_pulse(8'h15, 1'b1, 1'b0);
        chk("full_pop_count", 32'(c0), 32'd4);
        chk("full_pop_ovr", 32'(ov0), 32'd0);
        for (int i = 2; i <= 5; i++) check_pop(0, $sformatf("full_pop_rd%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);

        // Parity vectors
        for (int i = 0; i < 6; i++) begin
            send(1, tbl[i].data, 1'b1, tbl[i].par, tbl[i].stop, 10);
            chk($sformatf("vec%0d_count", i), 32'(c1), 32'd1);
            check_pop(1, $sformatf("vec%0d", i), tbl[i].data, tbl[i].exp_fe, tbl[i].exp_pe);
        end

        // Random bursts against a queue model of a 4-entry buffer
        for (int it = 0; it < 6; it++) begin
            model_q.delete();
            exp_ovr = 1'b0;
            nfr = $urandom_range(1, 6);
            for (int j = 0; j < nfr; j++) begin
                rnd_data = 8'($urandom);
                rnd_stop = ($urandom_range(0, 3) != 0);
                send(0, rnd_data, 1'b0, 1'b0, rnd_stop, $urandom_range(0, 20));
                cyc($urandom_range(1, 5));
                if (model_q.size() < 4) model_q.push_back({~rnd_stop, rnd_data});
                else exp_ovr = 1'b1;
            end
            chk($sformatf("rnd%0d_count", it), 32'(c0), 32'(model_q.size()));
            chk($sformatf("rnd%0d_ovr", it), 32'(ov0), 32'(exp_ovr));
            while (model_q.size() > 0) begin
                ent = model_q.pop_front();
                check_pop(0, $sformatf("rnd%0d", it), ent[7:0], ent[8], 1'b0);
            end
            clr0 = 1'b1;
            cyc(1);
            clr0 = 1'b0;
            chk($sformatf("rnd%0d_clr", it), 32'(ov0), 32'd0);
        end

        // Reset during D3 with one entry already buffered
        send(0, 8'h77, 1'b0, 1'b0, 1'b1, 0);
        chk("pre_rst_count", 32'(c0), 32'd1);
        rx0 = 1'b0;
        cyc(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx0 = ((8'h9A >> i) & 8'h01) != 0;
            cyc(BIT_CLK);
        end
        rx0 = 1'b1;
        cyc(8);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cyc(3);
        reset = 1'b0;
        cyc(20);
        chk("post_rst_count", 32'(c0), 32'd0);
        chk("post_rst_busy", 32'(bz0), 32'd0);
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1, 0);
        check_pop(0, "post_rst", 8'hC3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
